rom_note_sequencer: RTL

Synchronous per-channel sequencer that walks a note-message ROM and drives one playnote channel with a note number and note-on flag. It replaces the negedge-of-waiting address stepping and the separate delay unit with a single-clock FSM and an internal tempo prescaler. It sits between the channel's ROM (upstream) and playnote (downstream).

---
 rtl/rom_note_sequencer_pkg.sv | 30 +++
 rtl/rom_note_sequencer_tick_prescaler.sv | 29 ++
 rtl/rom_note_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/rom_note_sequencer_pkg.sv
// Shared definitions for the ROM note sequencer: ROM field widths,
// sequencer state encoding and the playnote note-range clamp.
package rom_note_sequencer_pkg;

  localparam int DEFAULT_NOTE_BITS  = 7;
  localparam int DEFAULT_DELAY_BITS = 12;
  localparam int NOTE_OUT_BITS      = 7;

  localparam int NOTE_MIN = 0;
  localparam int NOTE_MAX = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  // Offset note arrives as signed 9-bit; playnote only accepts 0..127.
  function automatic logic [NOTE_OUT_BITS-1:0] clamp_note(input logic signed [8:0] value);
    if (value < NOTE_MIN) begin
      return NOTE_OUT_BITS'(NOTE_MIN);
    end else if (value > NOTE_MAX) begin
      return NOTE_OUT_BITS'(NOTE_MAX);
    end else begin
      return value[NOTE_OUT_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/rom_note_sequencer_tick_prescaler.sv
// Tempo prescaler: emits one tick every CLOCKS_PER_TICK clocks while run is high.
module tick_prescaler #(
  parameter int CLOCKS_PER_TICK = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_BITS = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CLOCKS_PER_TICK - 1);

  logic [CNT_BITS-1:0] count;

  assign tick = run && !clear && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/rom_note_sequencer.sv
// Walks a note-message ROM and drives one playnote channel; single-clock FSM
// with an internal tempo prescaler replacing the old delay unit.
module rom_note_sequencer
  import rom_note_sequencer_pkg::*;
#(
  parameter int ADDRESS_BITS    = 10,
  parameter int NOTE_BITS       = DEFAULT_NOTE_BITS,
  parameter int DELAY_BITS      = DEFAULT_DELAY_BITS,
  parameter int MESSAGES_LEN    = 511,
  parameter int NOTE_OFFSET     = 0,
  parameter int CLOCKS_PER_TICK = 10000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              restart,
  output logic [ADDRESS_BITS-1:0]           rom_address,
  input  logic [NOTE_BITS+DELAY_BITS:0]     rom_q,
  output logic [NOTE_OUT_BITS-1:0]          note_out,
  output logic                              note_on_out,
  output logic                              msg_strobe,
  output logic                              loop_done
);

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(MESSAGES_LEN);
  localparam logic signed [8:0]       OFFSET9   = 9'(NOTE_OFFSET);

  seq_state_t            state;
  logic [DELAY_BITS-1:0] delay_count;

  logic                  rom_note_on;
  logic [NOTE_BITS-1:0]  rom_note;
  logic [DELAY_BITS-1:0] rom_delay;
  logic signed [8:0]     note_sum;

  logic presc_clear;
  logic presc_run;
  logic tick;

  assign rom_note_on = rom_q[NOTE_BITS+DELAY_BITS];
  assign rom_note    = rom_q[NOTE_BITS+DELAY_BITS-1:DELAY_BITS];
  assign rom_delay   = rom_q[DELAY_BITS-1:0];
  assign note_sum    = $signed(9'(rom_note)) + OFFSET9;

  // Prescaler is held at zero outside HOLD, so every message starts a fresh tick.
  assign presc_clear = restart || (state != HOLD);
  assign presc_run   = (state == HOLD) && (delay_count != '0);

  tick_prescaler #(
    .CLOCKS_PER_TICK(CLOCKS_PER_TICK)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_address <= '0;
      note_out    <= '0;
      note_on_out <= 1'b0;
      msg_strobe  <= 1'b0;
      loop_done   <= 1'b0;
      delay_count <= '0;
    end else begin
      msg_strobe <= 1'b0;
      loop_done  <= 1'b0;
      if (restart) begin
        rom_address <= '0;
        note_on_out <= 1'b0;
        delay_count <= '0;
        state       <= enable ? FETCH : IDLE;
      end else if (!enable) begin
        // rom_address is kept so re-enabling replays the interrupted message.
        note_on_out <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state <= FETCH;
          end
          FETCH: begin
            state <= READ;
          end
          READ: begin
            note_out    <= clamp_note(note_sum);
            note_on_out <= rom_note_on;
            delay_count <= rom_delay;
            msg_strobe  <= 1'b1;
            state       <= HOLD;
          end
          HOLD: begin
            if (delay_count == '0) begin
              state <= FETCH;
              if (rom_address == LAST_ADDR) begin
                rom_address <= '0;
                loop_done   <= 1'b1;
              end else begin
                rom_address <= rom_address + ADDRESS_BITS'(1);
              end
            end else if (tick) begin
              delay_count <= delay_count - DELAY_BITS'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
